ncpu32k_regfile_mp: RTL and testbench
=====================================

// Module: ncpu32k_regfile_mp
// PURPOSE
//  Parametrised multi-port register file for dual-issue and wider cores.
//  Has NR synchronous read ports and NW write ports, with r0 hardwired to zero.
//  Writes bypass to reads issued in the same cycle.
//  After reset, a built-in clear sequencer zeroes the array and holds ready low until done.
//  Sits between the decode stage (read) and writeback (write).
// PARAMETERS
//  AW             5   register address width; depth = 2**AW, r0 included
//  DW             32  data width
//  NR             2   number of read ports (>=1)
//  NW             1   number of write ports (>=1)
//  CLEAR_ON_INIT  1   1: sweep-clear after reset; 0: ready one cycle after reset, contents unchanged
//  ENABLE_BYPASS  1   1: same-cycle write is forwarded to a matching read
// PORTS
//  clk      in   1      clock
//  rst      in   1      synchronous reset, active-high
//  rd_addr  in   NR*AW  read address, port i in bits [i*AW +: AW]
//  rd_re    in   NR     read enable per port
//  rd_dout  out  NR*DW  read data, registered, port i in bits [i*DW +: DW]
//  rd_valid out  NR     rd_dout of port i was updated by the previous cycle's read
//  wr_addr  in   NW*AW  write address per port
//  wr_din   in   NW*DW  write data per port
//  wr_we    in   NW     write enable per port
//  ready    out  1      array usable; reads and writes are ignored while low
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - state<=CLEAR (or DONE if CLEAR_ON_INIT=0), clr_ptr<=1
//   - ready<=0, rd_dout<=0, rd_valid<=0
//   - Reset mid-sweep or mid-operation restarts the sweep from address 1
//  FSM states: CLEAR -> DONE
//   - CLEAR: one cycle per address, regs[clr_ptr]<=0, clr_ptr++
//     When clr_ptr==2**AW-1 is written, the next state is DONE
//     The sweep takes 2**AW-1 cycles: ready rises 2**AW cycles after rst deasserts (32 at AW=5)
//   - CLEAR_ON_INIT=0: ready rises the first cycle after rst deasserts
//   - DONE is absorbing until rst
//  Write, while ready
//   - Port j writes regs[wr_addr_j]<=wr_din_j at the posedge if wr_we_j=1 and wr_addr_j!=0
//   - Address 0 writes are dropped
//   - Several ports writing the same address: the highest port index wins
//  Read, while ready, 1-cycle latency
//   - rd_re_i=1 samples the address at the posedge; rd_dout_i<=value, rd_valid_i<=1
//   - value = 0 if addr==0
//   - else, if ENABLE_BYPASS and some wr_we_j hits the same address that cycle:
//     wr_din of the winning (highest) j, i.e. the new value
//   - else regs[addr] (the old value)
//   - rd_re_i=0: rd_dout_i holds its last value, rd_valid_i<=0
//  ready=0: rd_valid<=0, rd_dout holds, all wr_we are ignored
//  Read ports are fully independent; any number may read the same address
//  Array is plain flops/distributed RAM with no reset on the data itself; only the sweep clears it
// STRUCTURE
//  Shared package / ncpu32k_config.h: NCPU_REG_AW, NCPU_DW, state encodings RF_CLEAR and RF_DONE
//  Sub-module ncpu32k_regfile_rdport, one instance per read port (generate loop):
//   - zero check, priority bypass mux over NW writes, output/valid registers
//  Top level holds the array, the write priority decode, and the clear FSM/pointer
//  Expected size is about 200 lines of RTL
// TESTING
//  1. Clear sweep
//     - Write all-ones to regs via a backdoor, pulse rst for 1 cycle
//     - ready=0 for exactly 32 cycles (AW=5)
//     - Then read r1..r31 on both ports: all 0 with rd_valid=1
//  2. r0 hardwired
//     - wr_we=1, addr=0, din=32'hDEADBEEF
//     - The next cycle rd_re=1 on r0 returns 0
//  3. Bypass
//     - Same cycle: write r5=32'h1234_5678 and read r5 on ports 0 and 1
//     - Both rd_dout=32'h1234_5678 next cycle
//     - With ENABLE_BYPASS=0 both return the old value instead
//  4. Write conflict (NW=2)
//     - Port0 writes r7=32'hA, port1 writes r7=32'hB in the same cycle
//     - A later read of r7 returns 32'hB
//  5. Hold and valid
//     - Read r3=32'h55, then drop rd_re for 3 cycles while writing r3=32'h66
//     - rd_dout stays 32'h55 with rd_valid=0
//     - Re-reading r3 gives 32'h66
//  6. Reset mid-operation
//     - Assert rst at sweep cycle 10 and again after ready
//     - Each time ready drops and rises exactly 32 cycles after deassert
//     - Writes issued during the sweep are not retained

Source files
------------

// File: rtl/ncpu32k_regfile_mp_pkg.sv
// Shared configuration for the multi-port register file: default widths and
// the clear-sequencer state encoding.
package ncpu32k_regfile_mp_pkg;

  localparam int unsigned NCPU_REG_AW = 5;
  localparam int unsigned NCPU_DW     = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_DONE  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/ncpu32k_regfile_mp_if.sv
// Decode/writeback bus into the register file: NR read ports, NW write ports, ready.
interface ncpu32k_regfile_mp_if
  import ncpu32k_regfile_mp_pkg::*;
#(
  parameter int unsigned AW = NCPU_REG_AW,
  parameter int unsigned DW = NCPU_DW,
  parameter int unsigned NR = 2,
  parameter int unsigned NW = 1
);

  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]    rd_re;
  logic [NR*DW-1:0] rd_dout;
  logic [NR-1:0]    rd_valid;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_din;
  logic [NW-1:0]    wr_we;
  logic             ready;

  modport master (
    output rd_addr, rd_re, wr_addr, wr_din, wr_we,
    input  rd_dout, rd_valid, ready
  );

  modport slave (
    input  rd_addr, rd_re, wr_addr, wr_din, wr_we,
    output rd_dout, rd_valid, ready
  );

endinterface

// File: rtl/ncpu32k_regfile_rdport.sv
// One registered read port: r0 zero check, priority bypass over the write
// ports (highest index wins), output data and valid registers.
module ncpu32k_regfile_rdport
  import ncpu32k_regfile_mp_pkg::*;
#(
  parameter int unsigned AW            = NCPU_REG_AW,
  parameter int unsigned DW            = NCPU_DW,
  parameter int unsigned NW            = 1,
  parameter bit          ENABLE_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [DW-1:0]    i_old,
  input  logic [NW*AW-1:0] i_wr_addr,
  input  logic [NW*DW-1:0] i_wr_din,
  input  logic [NW-1:0]    i_wr_we,
  output logic [DW-1:0]    o_dout,
  output logic             o_valid
);

  logic [DW-1:0] w_val;
  logic [DW-1:0] r_dout;
  logic          r_valid;

  // Select the value to capture: zero for r0, newest write on a hit, else the array.
  always_comb begin
    w_val = i_old;
    for (int unsigned j = 0; j < NW; j++) begin
      if (ENABLE_BYPASS && i_wr_we[j] && (i_wr_addr[j*AW +: AW] == i_addr)) begin
        w_val = i_wr_din[j*DW +: DW];
      end
    end
    if (i_addr == '0) begin
      w_val = '0;
    end
  end

  // Capture read data on enable; data holds otherwise, valid tracks the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_en;
      if (i_en) begin
        r_dout <= w_val;
      end
    end
  end

  assign o_dout  = r_dout;
  assign o_valid = r_valid;

endmodule

// File: rtl/ncpu32k_regfile_mp.sv
// Multi-port register file: array, write priority decode, and post-reset
// clear sequencer. r0 reads as zero; ready gates all reads and writes.
module ncpu32k_regfile_mp
  import ncpu32k_regfile_mp_pkg::*;
#(
  parameter int unsigned AW            = NCPU_REG_AW,
  parameter int unsigned DW            = NCPU_DW,
  parameter int unsigned NR            = 2,
  parameter int unsigned NW            = 1,
  parameter bit          CLEAR_ON_INIT = 1'b1,
  parameter bit          ENABLE_BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  ncpu32k_regfile_mp_if.slave   bus
);

  localparam int unsigned DEPTH = 2**AW;

  rf_state_t     r_state;
  rf_state_t     w_state_nxt;
  logic [AW-1:0] r_clr_ptr;
  logic          r_ready;
  logic [DW-1:0] r_regs [DEPTH];
  logic [NW-1:0] w_wr_we;

  assign w_wr_we   = bus.wr_we & {NW{r_ready}};
  assign bus.ready = r_ready;

  // Sweep finishes once the last address has been cleared; DONE is absorbing.
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == RF_CLEAR) && (r_clr_ptr == '1)) begin
      w_state_nxt = RF_DONE;
    end
  end

  // State, clear pointer and ready; ready lags DONE by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR_ON_INIT ? RF_CLEAR : RF_DONE;
      r_clr_ptr <= AW'(1);
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RF_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + AW'(1);
      end
      r_ready <= (r_state == RF_DONE);
    end
  end

  // Array update: sweep clear, else ascending-port writes so the highest port wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == RF_CLEAR) begin
        r_regs[r_clr_ptr] <= '0;
      end else begin
        for (int unsigned j = 0; j < NW; j++) begin
          if (w_wr_we[j] && (bus.wr_addr[j*AW +: AW] != '0)) begin
            r_regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_din[j*DW +: DW];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [DW-1:0] w_old;
    assign w_old = r_regs[bus.rd_addr[i*AW +: AW]];

    ncpu32k_regfile_rdport #(
      .AW            (AW),
      .DW            (DW),
      .NW            (NW),
      .ENABLE_BYPASS (ENABLE_BYPASS)
    ) u_rdport (
      .clk       (clk),
      .rst       (rst),
      .i_en      (bus.rd_re[i] & r_ready),
      .i_addr    (bus.rd_addr[i*AW +: AW]),
      .i_old     (w_old),
      .i_wr_addr (bus.wr_addr),
      .i_wr_din  (bus.wr_din),
      .i_wr_we   (w_wr_we),
      .o_dout    (bus.rd_dout[i*DW +: DW]),
      .o_valid   (bus.rd_valid[i])
    );
  end

endmodule

// File: tb/tb_ncpu32k_regfile_mp.sv
// Bench for the multi-port register file: dut0 (NW=2, sweep, bypass) and
// dut1 (NW=1, no sweep, no bypass). Expected read data is queued at issue
// and checked by a monitor whenever a read port presents valid.
module tb_ncpu32k_regfile_mp;
  import ncpu32k_regfile_mp_pkg::*;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  ncpu32k_regfile_mp_if #(.AW(5), .DW(32), .NR(2), .NW(2)) bus0 ();
  ncpu32k_regfile_mp_if #(.AW(5), .DW(32), .NR(2), .NW(1)) bus1 ();

  ncpu32k_regfile_mp #(
    .AW(5), .DW(32), .NR(2), .NW(2), .CLEAR_ON_INIT(1'b1), .ENABLE_BYPASS(1'b1)
  ) u_dut0 (.clk(clk), .rst(rst0), .bus(bus0.slave));

  ncpu32k_regfile_mp #(
    .AW(5), .DW(32), .NR(2), .NW(1), .CLEAR_ON_INIT(1'b0), .ENABLE_BYPASS(1'b0)
  ) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));

  typedef struct {
    int unsigned tag;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.rd_re = '0; bus0.wr_we = '0;
    bus1.rd_re = '0; bus1.wr_we = '0;
  endtask

  task automatic push(int unsigned tag, logic [31:0] d);
    exp_t e;
    e.tag = tag; e.data = d;
    sb.push_back(e);
  endtask

  task automatic rd0(logic [4:0] a0, logic [4:0] a1, logic [1:0] re, logic [31:0] e0, logic [31:0] e1);
    bus0.rd_addr = {a1, a0};
    bus0.rd_re   = re;
    if (re[0]) push(0, e0);
    if (re[1]) push(1, e1);
  endtask

  task automatic rd1(logic [4:0] a0, logic [4:0] a1, logic [1:0] re, logic [31:0] e0, logic [31:0] e1);
    bus1.rd_addr = {a1, a0};
    bus1.rd_re   = re;
    if (re[0]) push(2, e0);
    if (re[1]) push(3, e1);
  endtask

  task automatic wr0(int unsigned p, logic [4:0] a, logic [31:0] d);
    bus0.wr_addr[p*5 +: 5]  = a;
    bus0.wr_din[p*32 +: 32] = d;
    bus0.wr_we[p]           = 1'b1;
  endtask

  task automatic wr1(logic [4:0] a, logic [31:0] d);
    bus1.wr_addr = a;
    bus1.wr_din  = d;
    bus1.wr_we   = 1'b1;
  endtask

  task automatic wait_ready0(int exp_n, string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus0.ready && n < 100);
    chk(name, 32'(n), 32'(exp_n));
  endtask

  // Scoreboard monitor: every presented read result must match the queue head.
  always @(negedge clk) begin : mon
    logic [3:0]  v;
    logic [31:0] d [4];
    exp_t        e;
    v    = {bus1.rd_valid, bus0.rd_valid};
    d[0] = bus0.rd_dout[31:0];
    d[1] = bus0.rd_dout[63:32];
    d[2] = bus1.rd_dout[31:0];
    d[3] = bus1.rd_dout[63:32];
    for (int k = 0; k < 4; k++) begin
      if (v[k]) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read port=%0d actual=%h required=no_valid", k, d[k]);
        end else begin
          e = sb.pop_front();
          if (e.tag != k || d[k] !== e.data) begin
            bad++;
            $display("FAIL read port=%0d (expected port %0d) actual=%h required=%h", k, e.tag, d[k], e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus0.rd_addr = '0; bus0.wr_addr = '0; bus0.wr_din = '0;
    bus1.rd_addr = '0; bus1.wr_addr = '0; bus1.wr_din = '0;
    idle();
    rst0 = 1'b1; rst1 = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_ready0", 32'(bus0.ready), 32'd0);
    chk("rst_valid0", 32'(bus0.rd_valid), 32'd0);
    chk("rst_dout0", bus0.rd_dout[31:0], 32'd0);
    chk("rst_dout1", bus0.rd_dout[63:32], 32'd0);
    rst1 = 1'b0;
    chk("rst_ready1", 32'(bus1.ready), 32'd0);
    tick();
    chk("noclear_ready1", 32'(bus1.ready), 32'd1);
    rst0 = 1'b0;
    wait_ready0(32, "init_ready_cycles");
    idle();

    // 1. Clear sweep: fill with ones, pulse reset, expect all zeros
    for (int a = 1; a < 32; a++) begin
      wr0(0, 5'(a), 32'hFFFF_FFFF);
      tick();
    end
    idle();
    rd0(5'd31, 5'd1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(); idle(); tick();
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    wait_ready0(32, "sweep_ready_cycles");
    for (int a = 1; a < 32; a++) begin
      rd0(5'(a), 5'(a), 2'b11, 32'd0, 32'd0);
      tick();
    end
    idle(); tick();

    // 2. r0 hardwired, including same-cycle bypass attempt
    wr0(0, 5'd0, 32'hDEAD_BEEF);
    rd0(5'd0, 5'd0, 2'b11, 32'd0, 32'd0);
    tick(); idle();
    rd0(5'd0, 5'd0, 2'b11, 32'd0, 32'd0);
    tick(); idle(); tick();

    // 3. Bypass on dut0; old value returned on dut1
    wr0(0, 5'd5, 32'h1234_5678);
    rd0(5'd5, 5'd5, 2'b11, 32'h1234_5678, 32'h1234_5678);
    tick(); idle(); tick();
    wr1(5'd5, 32'hCAFE_0001);
    tick(); idle();
    wr1(5'd5, 32'h1234_5678);
    rd1(5'd5, 5'd5, 2'b11, 32'hCAFE_0001, 32'hCAFE_0001);
    tick(); idle();
    rd1(5'd5, 5'd5, 2'b11, 32'h1234_5678, 32'h1234_5678);
    tick(); idle(); tick();

    // 4. Write conflict: highest port wins, in the array and on the bypass
    wr0(0, 5'd7, 32'hA); wr0(1, 5'd7, 32'hB);
    tick(); idle();
    rd0(5'd7, 5'd7, 2'b11, 32'hB, 32'hB);
    tick(); idle();
    wr0(0, 5'd9, 32'hA); wr0(1, 5'd9, 32'hB);
    rd0(5'd9, 5'd9, 2'b11, 32'hB, 32'hB);
    tick(); idle();
    rd0(5'd9, 5'd1, 2'b01, 32'hB, 32'd0);
    tick(); idle(); tick();

    // 5. Hold and valid
    wr0(0, 5'd3, 32'h55);
    tick(); idle();
    rd0(5'd3, 5'd0, 2'b01, 32'h55, 32'd0);
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      wr0(0, 5'd3, 32'h66);
      tick();
      chk("hold_dout", bus0.rd_dout[31:0], 32'h55);
      chk("hold_valid", 32'(bus0.rd_valid[0]), 32'd0);
    end
    idle();
    rd0(5'd3, 5'd3, 2'b11, 32'h66, 32'h66);
    tick(); idle(); tick();

    // 6. Reset mid-sweep and after ready; sweep-time writes are dropped
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    wr0(0, 5'd2, 32'h77);
    repeat (10) tick();
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    chk("midsweep_ready_low", 32'(bus0.ready), 32'd0);
    wait_ready0(32, "midsweep_ready_cycles");
    idle();
    rd0(5'd2, 5'd12, 2'b11, 32'd0, 32'd0);
    tick(); idle();
    wr0(0, 5'd4, 32'h99);
    tick(); idle();
    rd0(5'd4, 5'd4, 2'b11, 32'h99, 32'h99);
    tick(); idle(); tick();
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    chk("ready_drop", 32'(bus0.ready), 32'd0);
    wait_ready0(32, "rerst_ready_cycles");
    rd0(5'd4, 5'd2, 2'b11, 32'd0, 32'd0);
    tick(); idle(); tick(); tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
